// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes the raw PS/2 lines, debounces the clock and emits a
// one-cycle strobe when the filtered clock falls.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  assign data_sync = dat_sync[1];

  // Sync flops and filtered level reset high so the idle bus never
  // looks like a falling edge coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= 1'b0;
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard frame receiver: assembles 11-bit frames into scan codes
// and folds the F0 (break) and E0 (extended) prefixes into flags.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       code_break,
  output logic       code_ext,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          sdata;
  logic          fall;
  state_t        state, state_n;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          break_pend, ext_pend;
  logic          tmo, frame_ok;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (sdata),
    .fall      (fall)
  );

  always_comb begin
    tmo      = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));
    frame_ok = sdata && parity_ok(shreg, par_bit);
    state_n  = state;
    if (tmo) begin
      state_n = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!sdata) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
      code       <= '0;
      code_valid <= 1'b0;
      code_break <= 1'b0;
      code_ext   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TW'(1);

      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shreg   <= {sdata, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= sdata;
          STOP: begin
            if (!frame_ok) begin
              frame_err  <= 1'b1;
              break_pend <= 1'b0;
              ext_pend   <= 1'b0;
            end else if (shreg == PS2_BREAK) begin
              break_pend <= 1'b1;
            end else if (shreg == PS2_EXT) begin
              ext_pend <= 1'b1;
            end else begin
              // Prefix flags are consumed by the code they qualify.
              code       <= shreg;
              code_valid <= 1'b1;
              code_break <= break_pend;
              code_ext   <= ext_pend;
              break_pend <= 1'b0;
              ext_pend   <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (tmo) begin
        frame_err  <= 1'b1;
        break_pend <= 1'b0;
        ext_pend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: fixed frame table, randomized frames against a
// prefix-folding reference model, and timeout/glitch/reset sequences.
module tb_ps2_key_rx;

  localparam int FL  = 8;
  localparam int TO  = 200;
  localparam int H   = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid, code_break, code_ext, frame_err;

  ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .code_break (code_break),
    .code_ext   (code_ext),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int nv = 0, ne = 0, err_cyc = 0, fall_cyc = 0;
  logic [7:0] cap_code;
  logic       cap_brk, cap_ext, prev_v = 1'b0;
  logic [7:0] held_code = 8'h00;
  logic       ref_brk = 1'b0, ref_ext = 1'b0;

  typedef struct {
    logic [7:0] data;
    bit         pflip;
    bit         stop;
    bit         exp_valid;
    logic [7:0] exp_code;
    bit         exp_brk;
    bit         exp_ext;
    bit         exp_err;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (code_valid || frame_err) chk("valid_err_exclusive", {31'd0, code_valid & frame_err}, 0);
    if (code_valid) begin
      chk("valid_one_cycle", {31'd0, prev_v}, 0);
      nv++;
      cap_code = code;
      cap_brk  = code_break;
      cap_ext  = code_ext;
    end
    if (frame_err) begin
      ne++;
      err_cyc = cyc;
    end
    prev_v = code_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic lvl, input int len, input int gpos);
    for (int j = 0; j < len; j++) begin
      ps2_clk = (j == gpos) ? ~lvl : lvl;
      tick();
    end
    ps2_clk = lvl;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input bit gl);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      hold(1'b1, H/2, gl ? 4 : -1);
      fall_cyc = cyc;
      hold(1'b0, H, gl ? 16 : -1);
      hold(1'b1, H/2, -1);
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit pflip, input bit stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  task automatic run_frame(input string nm, input logic [7:0] d, input bit pflip, input bit stop,
                           input bit gl, input bit ev, input logic [7:0] ec, input bit eb,
                           input bit ee, input bit eerr);
    int nv0, ne0;
    nv0 = nv;
    ne0 = ne;
    send_bits(frame_bits(d, pflip, stop), 11, gl);
    repeat (20) tick();
    chk({nm, "_nvalid"}, nv - nv0, {31'd0, ev});
    chk({nm, "_nerr"}, ne - ne0, {31'd0, eerr});
    if (ev) begin
      chk({nm, "_code"}, {24'd0, cap_code}, {24'd0, ec});
      chk({nm, "_break"}, {31'd0, cap_brk}, {31'd0, eb});
      chk({nm, "_ext"}, {31'd0, cap_ext}, {31'd0, ee});
      held_code = ec;
    end
    chk({nm, "_code_held"}, {24'd0, code}, {24'd0, held_code});
  endtask

  initial begin
    int nv0, ne0, lat, r;
    logic [7:0] d;
    bit pf, st, eerr, ev;
    logic [7:0] ec;
    bit eb, ee;

    tbl[0]  = '{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0};
    tbl[1]  = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[3]  = '{8'h75, 0, 1, 1, 8'h75, 1, 1, 0};
    tbl[4]  = '{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0};
    tbl[5]  = '{8'h1C, 1, 1, 0, 8'h00, 0, 0, 1};
    tbl[6]  = '{8'hF0, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[7]  = '{8'h1C, 0, 1, 1, 8'h1C, 1, 0, 0};
    tbl[8]  = '{8'hE0, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[9]  = '{8'h5A, 0, 0, 0, 8'h00, 0, 0, 1};
    tbl[10] = '{8'h1C, 0, 1, 1, 8'h1C, 0, 0, 0};
    tbl[11] = '{8'hFF, 0, 1, 1, 8'hFF, 0, 0, 0};
    tbl[12] = '{8'h00, 0, 1, 1, 8'h00, 0, 0, 0};

    repeat (5) tick();
    chk("rst_code", {24'd0, code}, 0);
    chk("rst_outs", {28'd0, code_valid, code_break, code_ext, frame_err}, 0);
    rst = 1'b0;
    repeat (30) tick();
    chk("idle_no_pulses", nv + ne, 0);

    for (int i = 0; i < 13; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].pflip, tbl[i].stop, 1'b0,
                tbl[i].exp_valid, tbl[i].exp_code, tbl[i].exp_brk, tbl[i].exp_ext, tbl[i].exp_err);

    // Random frames against the prefix-folding model.
    ref_brk = 1'b0;
    ref_ext = 1'b0;
    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, 5);
      d  = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom);
      pf = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 9) != 0);
      eerr = pf || !st;
      ev = 1'b0; ec = 8'h00; eb = 1'b0; ee = 1'b0;
      if (eerr) begin
        ref_brk = 1'b0; ref_ext = 1'b0;
      end else if (d == 8'hF0) ref_brk = 1'b1;
      else if (d == 8'hE0) ref_ext = 1'b1;
      else begin
        ev = 1'b1; ec = d; eb = ref_brk; ee = ref_ext;
        ref_brk = 1'b0; ref_ext = 1'b0;
      end
      run_frame($sformatf("rnd%0d", i), d, pf, st, 1'b0, ev, ec, eb, ee, eerr);
    end
    // Flush any pending prefix so the sequences below start clean.
    run_frame("flush", 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Abandoned frame: start plus 4 data bits, then silence.
    nv0 = nv;
    ne0 = ne;
    send_bits(frame_bits(8'hA5, 1'b0, 1'b1), 5, 1'b0);
    for (int i = 0; i < 400 && ne == ne0; i++) tick();
    lat = err_cyc - fall_cyc;
    chk("tmo_err_count", ne - ne0, 1);
    chk("tmo_no_valid", nv - nv0, 0);
    chk("tmo_latency_window", {31'd0, (lat >= TO) && (lat <= TO + FL + 8)}, 1);
    run_frame("after_tmo", 8'h29, 1'b0, 1'b1, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0, 1'b0);

    run_frame("glitch", 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    nv0 = nv;
    ne0 = ne;
    send_bits(frame_bits(8'h3B, 1'b0, 1'b1), 6, 1'b0);
    rst = 1'b1;
    repeat (4) tick();
    chk("midrst_code", {24'd0, code}, 0);
    chk("midrst_outs", {28'd0, code_valid, code_break, code_ext, frame_err}, 0);
    rst = 1'b0;
    held_code = 8'h00;
    repeat (TO + 100) tick();
    chk("midrst_no_valid", nv - nv0, 0);
    chk("midrst_no_err", ne - ne0, 0);
    run_frame("after_rst", 8'h32, 1'b0, 1'b1, 1'b0, 1'b1, 8'h32, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
